// File: rtl/rotr_64b_pkg.sv
// Shared constants, stage record and rotate helper for the 64-bit rotate-right pipeline.
package rotr_64b_pkg;

  localparam int DATA_W  = 64;
  localparam int SHIFT_W = 6;

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  data;
    logic [SHIFT_W-1:0] shift;
  } rotr_stage_t;

  // Rotating a doubled word avoids the shift-by-width corner at amount 0.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0]  d,
                                             input logic [SHIFT_W-1:0] amt);
    logic [2*DATA_W-1:0] dd;
    dd = {d, d} >> amt;
    return dd[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/rotr_64b_stage.sv
// One rotate stage: rotates by SCALE*shift[1:0], forwards the remaining shift bits,
// and is either a registered pipeline slot (REG=1) or pure combinational pass-through.
module rotr_64b_stage
  import rotr_64b_pkg::*;
#(
  parameter int SCALE = 1,
  parameter bit REG   = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               succ_ready_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [SHIFT_W-1:0] shift_o
);

  logic [SHIFT_W-1:0] amt;
  logic [DATA_W-1:0]  rot_data;

  assign amt      = SHIFT_W'(SCALE) * {{(SHIFT_W-2){1'b0}}, shift_i[1:0]};
  assign rot_data = rotr(data_i, amt);

  generate
    if (REG) begin : g_reg
      rotr_stage_t stage_q;
      rotr_stage_t stage_d;

      assign ready_o = !stage_q.valid || succ_ready_i;

      // Data only loads with a valid operand so an emptied slot keeps its old contents.
      always_comb begin
        stage_d = stage_q;
        if (ready_o) begin
          stage_d.valid = valid_i;
          if (valid_i) begin
            stage_d.data  = rot_data;
            stage_d.shift = shift_i >> 2;
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign valid_o = stage_q.valid;
      assign data_o  = stage_q.data;
      assign shift_o = stage_q.shift;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_n_i;

      assign ready_o = succ_ready_i;
      assign valid_o = valid_i;
      assign data_o  = valid_i ? rot_data : '0;
      assign shift_o = valid_i ? (shift_i >> 2) : '0;
    end
  endgenerate

endmodule

// File: rtl/rotr_64b_pipe.sv
// 64-bit rotate-right, three stages (1x, 4x, 16x) with valid/ready flow control.
// Define ROTR_64B_REG_OUT_EN to register the last stage (latency 3); otherwise it is combinational (latency 2).
module rotr_64b_pipe
  import rotr_64b_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

`ifdef ROTR_64B_REG_OUT_EN
  localparam bit S3_REG = 1'b1;
`else
  localparam bit S3_REG = 1'b0;
`endif

  logic               s1_valid, s2_valid;
  logic [DATA_W-1:0]  s1_data, s2_data;
  logic [SHIFT_W-1:0] s1_shift, s2_shift, unused_s3_shift;
  logic               s2_ready, s3_ready;

  rotr_64b_stage #(.SCALE(1), .REG(1'b1)) u_s1 (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .valid_i      (in_valid_i),
    .data_i       (in_data_i),
    .shift_i      (shift_i),
    .succ_ready_i (s2_ready),
    .ready_o      (in_ready_o),
    .valid_o      (s1_valid),
    .data_o       (s1_data),
    .shift_o      (s1_shift)
  );

  rotr_64b_stage #(.SCALE(4), .REG(1'b1)) u_s2 (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .valid_i      (s1_valid),
    .data_i       (s1_data),
    .shift_i      (s1_shift),
    .succ_ready_i (s3_ready),
    .ready_o      (s2_ready),
    .valid_o      (s2_valid),
    .data_o       (s2_data),
    .shift_o      (s2_shift)
  );

  rotr_64b_stage #(.SCALE(16), .REG(S3_REG)) u_s3 (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .valid_i      (s2_valid),
    .data_i       (s2_data),
    .shift_i      (s2_shift),
    .succ_ready_i (out_ready_i),
    .ready_o      (s3_ready),
    .valid_o      (out_valid_o),
    .data_o       (out_data_o),
    .shift_o      (unused_s3_shift)
  );

endmodule

// File: tb/tb_rotr_64b_pipe.sv
// Directed self-checking bench for rotr_64b_pipe; follows ROTR_64B_REG_OUT_EN for latency and depth.
module tb_rotr_64b_pipe;

`ifdef ROTR_64B_REG_OUT_EN
  localparam int LAT   = 3;
  localparam int DEPTH = 3;
`else
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [5:0]  shift;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [63:0] exp_q[$];
  int          acc_q[$];
  int          cons_q[$];

  rotr_64b_pipe dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .shift_i     (shift),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] d, input int s);
    logic [127:0] t;
    t = {d, d} << s;
    return t[127:64];
  endfunction

  // Scoreboard: every consumed result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      cons_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {63'b0, out_valid}, 64'd0);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 64'hbad0_bad0_bad0_bad0;
    shift    = 6'($urandom_range(63));
  endtask

  task automatic send(input logic [63:0] d, input logic [5:0] s, input logic [63:0] e);
    int waited = 0;
    in_data  = d;
    shift    = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("send_timeout", {63'b0, in_ready}, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({"drain_", tag}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic measure_latency(input string tag);
    int n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    // counted from the accepting edge, so one less than the end-to-end latency
    chk(tag, 64'(n), 64'(LAT - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold;
    logic [63:0] bp_e[4];
    int a0, c0;
    bp_e[0] = 64'h8000_0000_0000_0000;
    bp_e[1] = 64'h4000_0000_0000_0000;
    bp_e[2] = 64'h2000_0000_0000_0000;
    bp_e[3] = 64'h1000_0000_0000_0000;

    rst_n = 1'b0;
    out_ready = 1'b1;
    idle();
    cycles(2);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);

    // basic rotate and latency
    send(64'h0123_4567_89ab_cdef, 6'd4, 64'hf012_3456_789a_bcde);
    idle();
    measure_latency("basic_latency");
    chk("basic_data", out_data, 64'hf012_3456_789a_bcde);
    drain("basic");

    // boundary shifts
    send(64'hfedc_ba98_7654_3210, 6'd63, 64'hfdb9_7530_eca8_6421);
    send(64'h0123_4567_89ab_cdef, 6'd32, 64'h89ab_cdef_0123_4567);
    send(64'hdead_beef_cafe_f00d, 6'd0,  64'hdead_beef_cafe_f00d);
    send(64'h0000_0000_0000_0001, 6'd1,  64'h8000_0000_0000_0000);
    idle();
    drain("boundary");

    // streaming: every amount, pre-rotated left, must come back to the constant
    a0 = acc_q.size();
    c0 = cons_q.size();
    for (int s = 0; s < 64; s++) begin
      send(rotl(64'h0123_4567_89ab_cdef, s), 6'(s), 64'h0123_4567_89ab_cdef);
    end
    idle();
    drain("stream");
    chk("stream_acc_span", 64'(acc_q[acc_q.size()-1] - acc_q[a0]), 64'd63);
    chk("stream_cons_cnt", 64'(cons_q.size() - c0), 64'd64);
    chk("stream_cons_span", 64'(cons_q[cons_q.size()-1] - cons_q[c0]), 64'd63);

    // backpressure: pipeline fills, then stalls with stable output
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(64'h1, 6'(i + 1), bp_e[i]);
    end
    in_data  = 64'h1;
    shift    = 6'(DEPTH + 1);
    in_valid = 1'b1;
    cycles(1);
    hold = out_data;
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_head", hold, bp_e[0]);
    cycles(4);
    chk("bp_stable", out_data, hold);
    chk("bp_in_ready_held", {63'b0, in_ready}, 64'd0);
    chk("bp_pending", 64'(exp_q.size()), 64'(DEPTH));
    out_ready = 1'b1;
    for (int i = DEPTH; i < 4; i++) begin
      send(64'h1, 6'(i + 1), bp_e[i]);
    end
    idle();
    drain("bp");

    // reset with operands in flight
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(64'haaaa_5555_aaaa_5555, 6'd5, 64'h0);
    end
    idle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mr_out_data", out_data, 64'h0);
    chk("mr_in_ready", {63'b0, in_ready}, 64'd1);
    exp_q.delete();
    out_ready = 1'b1;
    cycles(2);
    c0 = cons_q.size();
    @(negedge clk);
    rst_n    = 1'b1;
    in_data  = 64'h0123_4567_89ab_cdef;
    shift    = 6'd32;
    in_valid = 1'b1;
    #1;
    chk("mr_release_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    exp_q.push_back(64'h89ab_cdef_0123_4567);
    idle();
    measure_latency("mr_latency");
    drain("mr");
    cycles(5);
    chk("mr_cons_cnt", 64'(cons_q.size() - c0), 64'd1);

    // full pipe concurrency: 20 back-to-back, each result is its own index
    a0 = acc_q.size();
    c0 = cons_q.size();
    for (int i = 0; i < 20; i++) begin
      send(64'(i) << (i + 1), 6'(i + 1), 64'(i));
    end
    idle();
    drain("full");
    chk("full_acc_span", 64'(acc_q[acc_q.size()-1] - acc_q[a0]), 64'd19);
    chk("full_cons_cnt", 64'(cons_q.size() - c0), 64'd20);
    chk("full_cons_span", 64'(cons_q[cons_q.size()-1] - cons_q[c0]), 64'd19);

    cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
